axi_slave_write_ctrl: RTL

Slave-side AXI4 write responder that terminates the AW/W/B channels delivered by the interconnect for one memory slave, such as instruction or data SRAM. It accepts one write burst at a time, converts each W beat into a single-cycle SRAM byte-masked write, and returns a B response carrying the interconnect-extended ID. One instance sits in each SRAM wrapper, facing the interconnect's AW/W/B slave-port outputs.

---
 rtl/axi_slave_write_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/axi_slave_write_ctrl.sv
// AXI4 slave write responder for one SRAM: accepts one AW/W burst at a time,
// turns each W beat into a byte-masked SRAM write and answers on B.
module axi_slave_write_ctrl #(
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int MEM_AW = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDS_W-1:0]      AWID,
  input  logic [ADDR_W-1:0]     AWADDR,
  input  logic [LEN_W-1:0]      AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_W-1:0]     WDATA,
  input  logic [DATA_W/8-1:0]   WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [IDS_W-1:0]      BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic                  CEB,
  output logic                  WEB,
  output logic [DATA_W-1:0]     BWEB,
  output logic [MEM_AW-1:0]     A,
  output logic [DATA_W-1:0]     DI
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDS_W-1:0]   id_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [1:0]         burst_q;
  logic [MEM_AW-1:0]  addr_q;
  logic               err_q;

  logic aw_hs;
  logic w_hs;
  logic final_beat;
  logic bad_ctrl;
  logic wr_en;
  logic addr_unused;

  assign aw_hs       = (state_q == IDLE) && AWVALID;
  assign w_hs        = (state_q == DATA) && WVALID;
  assign final_beat  = (cnt_q == len_q);
  assign bad_ctrl    = AWBURST[1] || (AWSIZE != 3'b010);
  assign wr_en       = w_hs && !err_q;
  assign addr_unused = ^{AWADDR[ADDR_W-1:MEM_AW+2], AWADDR[1:0]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (AWVALID) state_d = DATA;
      DATA: if (w_hs && (final_beat || WLAST)) state_d = RESP;
      RESP: if (BREADY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A WLAST that disagrees with the beat count (early or missing) poisons the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (aw_hs) begin
        id_q    <= AWID;
        len_q   <= AWLEN;
        burst_q <= AWBURST;
        addr_q  <= AWADDR[MEM_AW+1:2];
        cnt_q   <= '0;
        err_q   <= bad_ctrl;
      end else if (w_hs) begin
        cnt_q <= cnt_q + 1'b1;
        if (burst_q == 2'b01) addr_q <= addr_q + 1'b1;
        err_q <= err_q | (final_beat ^ WLAST);
      end
    end
  end

  assign AWREADY = (state_q == IDLE);
  assign WREADY  = (state_q == DATA);
  assign BVALID  = (state_q == RESP);
  assign BID     = id_q;
  assign BRESP   = (state_q == RESP && err_q) ? 2'b10 : 2'b00;

  assign CEB = ~wr_en;
  assign WEB = ~wr_en;
  assign A   = addr_q;
  assign DI  = w_hs ? WDATA : '0;

  for (genvar i = 0; i < DATA_W/8; i++) begin : g_bweb
    assign BWEB[8*i +: 8] = {8{~(w_hs & WSTRB[i])}};
  end

endmodule
